wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 136 +++++++++++++
 tb/tb_wb_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load results into one register-file write port, one retire per cycle.
// Define WB_QUEUE_FORWARD_EN to compile in read-port forwarding from pending entries.
module wb_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         AluValid,
    input  logic [3:0]   AluAddr,
    input  logic [W-1:0] AluData,
    input  logic         LdValid,
    input  logic [3:0]   LdAddr,
    input  logic [W-1:0] LdData,
    output logic         WriteEn,
    output logic [3:0]   Waddr,
    output logic [W-1:0] DataIn,
    output logic         Stall,
    output logic         Overflow,
    input  logic [3:0]   RaddrA,
    input  logic [3:0]   RaddrB,
    output logic         FwdHitA,
    output logic [W-1:0] FwdDataA,
    output logic         FwdHitB,
    output logic [W-1:0] FwdDataB
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW:0] ONE     = (CW+1)'(1);
    localparam logic [CW:0] TWO     = (CW+1)'(2);

    typedef struct packed {
        logic [3:0]   addr;
        logic [W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head_reg, tail_reg, head_next, tail_next, alu_slot;
    logic [CW-1:0]   count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic            pop, ld_accept, alu_accept;
    logic [CW:0]     free_slots;
    logic [1:0]      n_push;

    // Free slots include the slot vacated by this cycle's pop.
    always_comb begin
        pop        = (count_reg != '0);
        free_slots = DEPTH_W - {1'b0, count_reg} + (CW+1)'(pop);
        ld_accept  = LdValid && (free_slots >= ONE);
        alu_accept = AluValid && (free_slots >= (ld_accept ? TWO : ONE));
        n_push     = {1'b0, ld_accept} + {1'b0, alu_accept};
        alu_slot   = tail_reg + PW'(ld_accept);
        head_next  = head_reg + PW'(pop);
        tail_next  = tail_reg + PW'(n_push);
        count_next = count_reg - CW'(pop) + CW'(n_push);
        overflow_next = overflow_reg
                        || (LdValid && !ld_accept)
                        || (AluValid && !alu_accept);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is not reset; entries outside the valid window are never observed.
    always_ff @(posedge Clk) begin
        if (ld_accept)
            mem[tail_reg] <= '{addr: LdAddr, data: LdData};
        if (alu_accept)
            mem[alu_slot] <= '{addr: AluAddr, data: AluData};
    end

    always_comb begin
        WriteEn  = pop;
        Waddr    = pop ? mem[head_reg].addr : 4'd0;
        DataIn   = pop ? mem[head_reg].data : '0;
        Stall    = (DEPTH_W - {1'b0, count_reg}) < TWO;
        Overflow = overflow_reg;
    end

`ifdef WB_QUEUE_FORWARD_EN
    logic [DEPTH-1:0] match_a, match_b;
    logic [W-1:0]     age_data [DEPTH];

    // Slot gi holds the gi-th oldest pending entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] idx;
            logic          live;
            assign idx          = head_reg + PW'(gi);
            assign live         = CW'(gi) < count_reg;
            assign age_data[gi] = mem[idx].data;
            assign match_a[gi]  = live && (mem[idx].addr == RaddrA);
            assign match_b[gi]  = live && (mem[idx].addr == RaddrB);
        end
    endgenerate

    always_comb begin
        FwdHitA  = 1'b0;
        FwdDataA = '0;
        FwdHitB  = 1'b0;
        FwdDataB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_a[i]) begin
                FwdHitA  = 1'b1;
                FwdDataA = age_data[i];
            end
            if (match_b[i]) begin
                FwdHitB  = 1'b1;
                FwdDataB = age_data[i];
            end
        end
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^{RaddrA, RaddrB};
    assign FwdHitA  = 1'b0;
    assign FwdDataA = '0;
    assign FwdHitB  = 1'b0;
    assign FwdDataB = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (W=8, DEPTH=4); forwarding checks follow WB_QUEUE_FORWARD_EN.
module tb_wb_queue;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       AluValid, LdValid;
    logic [3:0] AluAddr, LdAddr, RaddrA, RaddrB;
    logic [7:0] AluData, LdData;
    logic       WriteEn, Stall, Overflow, FwdHitA, FwdHitB;
    logic [3:0] Waddr;
    logic [7:0] DataIn, FwdDataA, FwdDataB;

    int checks = 0;
    int failures = 0;

    wb_queue #(.W(8), .DEPTH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData),
        .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Stall(Stall), .Overflow(Overflow),
        .RaddrA(RaddrA), .RaddrB(RaddrB),
        .FwdHitA(FwdHitA), .FwdDataA(FwdDataA),
        .FwdHitB(FwdHitB), .FwdDataB(FwdDataB)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        AluValid = 1'b0; AluAddr = 4'd0; AluData = 8'd0;
        LdValid  = 1'b0; LdAddr  = 4'd0; LdData  = 8'd0;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        idle_inputs();
        RaddrA = 4'd0; RaddrB = 4'd0;
        Reset_n = 1'b0;
        #12;
        got = {WriteEn, Waddr, DataIn, Stall, Overflow, FwdHitA, FwdHitB, FwdDataA[3:0]};
        checks++;
        if (got !== 23'd0 || FwdDataA !== 8'd0 || FwdDataB !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h fa=%h fb=%h want all zero", got, FwdDataA, FwdDataB);
        end else $display("pass reset_outputs");
        // Push presented while reset releases must land at the first edge.
        @(negedge Clk);
        Reset_n = 1'b1;
        AluValid = 1'b1; AluAddr = 4'd7; AluData = 8'h77;
        tick();
        idle_inputs();
        checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 4'd7, 8'h77}) begin
            failures++;
            $display("FAIL reset_release_push got=%b/%h/%h want 1/7/77", WriteEn, Waddr, DataIn);
        end else $display("pass reset_release_push addr=%h data=%h", Waddr, DataIn);
        tick();
        checks++;
        if (WriteEn !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_drain WriteEn=%b want 0", WriteEn);
        end else $display("pass reset_release_drain");
    endtask

    task automatic test_single();
        AluValid = 1'b1; AluAddr = 4'd3; AluData = 8'h5A;
        checks++;
        if (WriteEn !== 1'b0) begin
            failures++;
            $display("FAIL single_no_early_write WriteEn=%b want 0", WriteEn);
        end else $display("pass single_no_early_write");
        tick();
        idle_inputs();
        checks++;
        if ({WriteEn, Waddr, DataIn, Stall} !== {1'b1, 4'd3, 8'h5A, 1'b0}) begin
            failures++;
            $display("FAIL single_write got=%b/%h/%h stall=%b want 1/3/5a stall=0", WriteEn, Waddr, DataIn, Stall);
        end else $display("pass single_write addr=%h data=%h", Waddr, DataIn);
        tick();
        checks++;
        if (WriteEn !== 1'b0) begin
            failures++;
            $display("FAIL single_drain WriteEn=%b want 0", WriteEn);
        end else $display("pass single_drain");
    endtask

    task automatic test_same_addr_order();
        LdValid = 1'b1; LdAddr = 4'd2; LdData = 8'h11;
        AluValid = 1'b1; AluAddr = 4'd2; AluData = 8'h22;
        tick();
        idle_inputs();
        checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 4'd2, 8'h11}) begin
            failures++;
            $display("FAIL order_first got=%b/%h/%h want 1/2/11", WriteEn, Waddr, DataIn);
        end else $display("pass order_first addr=%h data=%h", Waddr, DataIn);
        tick();
        checks++;
        if ({WriteEn, Waddr, DataIn} !== {1'b1, 4'd2, 8'h22}) begin
            failures++;
            $display("FAIL order_second got=%b/%h/%h want 1/2/22", WriteEn, Waddr, DataIn);
        end else $display("pass order_second addr=%h data=%h", Waddr, DataIn);
        tick();
        checks++;
        if (WriteEn !== 1'b0) begin
            failures++;
            $display("FAIL order_drain WriteEn=%b want 0", WriteEn);
        end else $display("pass order_drain");
    endtask

    task automatic test_forward();
        logic       exp_hit_a, exp_hit_b;
        logic [7:0] exp_data_a;
`ifdef WB_QUEUE_FORWARD_EN
        exp_hit_a = 1'b1; exp_hit_b = 1'b0; exp_data_a = 8'h02;
`else
        exp_hit_a = 1'b0; exp_hit_b = 1'b0; exp_data_a = 8'h00;
`endif
        RaddrA = 4'd5; RaddrB = 4'd6;
        LdValid = 1'b1; LdAddr = 4'd5; LdData = 8'h01;
        AluValid = 1'b1; AluAddr = 4'd5; AluData = 8'h02;
        #1;
        checks++;
        if (FwdHitA !== 1'b0) begin
            failures++;
            $display("FAIL fwd_no_incoming FwdHitA=%b want 0", FwdHitA);
        end else $display("pass fwd_no_incoming");
        tick();
        idle_inputs();
        checks++;
        if ({FwdHitA, FwdDataA} !== {exp_hit_a, exp_data_a}) begin
            failures++;
            $display("FAIL fwd_youngest_a got=%b/%h want %b/%h", FwdHitA, FwdDataA, exp_hit_a, exp_data_a);
        end else $display("pass fwd_youngest_a hit=%b data=%h", FwdHitA, FwdDataA);
        checks++;
        if ({FwdHitB, FwdDataB} !== {exp_hit_b, 8'h00}) begin
            failures++;
            $display("FAIL fwd_miss_b got=%b/%h want 0/00", FwdHitB, FwdDataB);
        end else $display("pass fwd_miss_b");
        tick();
        tick();
        checks++;
        if ({FwdHitA, WriteEn} !== 2'b00) begin
            failures++;
            $display("FAIL fwd_after_drain hit=%b we=%b want 0/0", FwdHitA, WriteEn);
        end else $display("pass fwd_after_drain");
        RaddrA = 4'd0; RaddrB = 4'd0;
    endtask

    task automatic test_overflow();
        // Four dual pushes; the fourth ALU push finds no slot.
        logic [3:0] exp_stall;
        exp_stall = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            LdValid = 1'b1;  LdAddr  = 4'(2*c);     LdData  = 8'h40 + 8'(2*c);
            AluValid = 1'b1; AluAddr = 4'(2*c + 1); AluData = 8'h40 + 8'(2*c + 1);
            tick();
            checks++;
            if ({Stall, Overflow} !== {exp_stall[c], c == 3}) begin
                failures++;
                $display("FAIL ovf_cycle%0d stall=%b ovf=%b want %b/%b", c, Stall, Overflow, exp_stall[c], c == 3);
            end else $display("pass ovf_cycle%0d stall=%b ovf=%b", c, Stall, Overflow);
        end
        idle_inputs();
        // Remaining queue: A1(3/43), L2(4/44), A2(5/45), L3(6/46).
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({WriteEn, Waddr, DataIn} !== {1'b1, 4'(3 + k), 8'h43 + 8'(k)}) begin
                failures++;
                $display("FAIL ovf_drain%0d got=%b/%h/%h want 1/%h/%h", k, WriteEn, Waddr, DataIn, 4'(3 + k), 8'h43 + 8'(k));
            end else $display("pass ovf_drain%0d addr=%h data=%h", k, Waddr, DataIn);
            tick();
        end
        checks++;
        if ({WriteEn, Overflow, Stall} !== 3'b010) begin
            failures++;
            $display("FAIL ovf_sticky we=%b ovf=%b stall=%b want 0/1/0", WriteEn, Overflow, Stall);
        end else $display("pass ovf_sticky");
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 2; c++) begin
            LdValid = 1'b1;  LdAddr  = 4'd9; LdData  = 8'h90;
            AluValid = 1'b1; AluAddr = 4'd9; AluData = 8'h91;
            tick();
        end
        idle_inputs();
        checks++;
        if ({WriteEn, Stall, Overflow} !== 3'b111) begin
            failures++;
            $display("FAIL areset_pre we=%b stall=%b ovf=%b want 1/1/1", WriteEn, Stall, Overflow);
        end else $display("pass areset_pre");
        #3;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({WriteEn, Stall, Overflow, Waddr, DataIn} !== 15'd0) begin
            failures++;
            $display("FAIL areset_immediate we=%b stall=%b ovf=%b a=%h d=%h want zeros", WriteEn, Stall, Overflow, Waddr, DataIn);
        end else $display("pass areset_immediate");
        tick();
        #2;
        Reset_n = 1'b1;
        tick();
        checks++;
        if ({WriteEn, Overflow} !== 2'b00) begin
            failures++;
            $display("FAIL areset_no_stale we=%b ovf=%b want 0/0", WriteEn, Overflow);
        end else $display("pass areset_no_stale");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            AluValid = 1'b1; AluAddr = 4'(k); AluData = 8'h30 + 8'(k);
            tick();
            checks++;
            if ({WriteEn, Waddr, DataIn, Stall} !== {1'b1, 4'(k), 8'h30 + 8'(k), 1'b0}) begin
                failures++;
                $display("FAIL b2b_%0d got=%b/%h/%h stall=%b want 1/%h/%h stall=0", k, WriteEn, Waddr, DataIn, Stall, 4'(k), 8'h30 + 8'(k));
            end else $display("pass b2b_%0d addr=%h data=%h", k, Waddr, DataIn);
        end
        idle_inputs();
        tick();
        checks++;
        if ({WriteEn, Overflow} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_drain we=%b ovf=%b want 0/0", WriteEn, Overflow);
        end else $display("pass b2b_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_addr_order();
        test_forward();
        test_overflow();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
